// File: rtl/dcache_mem_responder_pkg.sv
// Shared widths, state type and defaults for the dcache main-memory responder.
package dcache_mem_responder_pkg;

  localparam int DCACHE_ADDR_WIDTH  = 32;
  localparam int DCACHE_LINE_WIDTH  = 128;
  localparam int DCACHE_OFFSET_BITS = 4;

  localparam int MEM_DEPTH_DEFAULT = 1024;
  localparam int MEM_IDX_BITS      = $clog2(MEM_DEPTH_DEFAULT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } type_mem_resp_state_e;

endpackage

// File: rtl/dcache_mem_responder_if.sv
// dcache <-> main memory line request bus.
// DCACHE_MEM_ERR_EN adds the mem2dcache_err_o out-of-range flag.
interface dcache_mem_responder_if;
  import dcache_mem_responder_pkg::*;

  logic                         dcache2mem_req_i;
  logic                         dcache2mem_wr_i;
  logic [DCACHE_ADDR_WIDTH-1:0] dcache2mem_addr_i;
  logic [DCACHE_LINE_WIDTH-1:0] dcache2mem_data_i;
  logic [DCACHE_LINE_WIDTH-1:0] mem2dcache_data_o;
  logic                         mem2dcache_ack_o;
  logic                         mem_busy_o;
`ifdef DCACHE_MEM_ERR_EN
  logic                         mem2dcache_err_o;
`endif

  modport master (
    output dcache2mem_req_i, dcache2mem_wr_i, dcache2mem_addr_i, dcache2mem_data_i,
`ifdef DCACHE_MEM_ERR_EN
    input  mem2dcache_err_o,
`endif
    input  mem2dcache_data_o, mem2dcache_ack_o, mem_busy_o
  );

  modport slave (
    input  dcache2mem_req_i, dcache2mem_wr_i, dcache2mem_addr_i, dcache2mem_data_i,
`ifdef DCACHE_MEM_ERR_EN
    output mem2dcache_err_o,
`endif
    output mem2dcache_data_o, mem2dcache_ack_o, mem_busy_o
  );

endinterface

// File: rtl/dcache_mem_responder_array.sv
// Single-port line store with registered read; contents are never reset.
module dcache_mem_array #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 128
) (
  input  logic                     clk,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dcache_mem_responder.sv
// Fixed-latency main-memory responder for dcache line fills and writebacks.
// Define DCACHE_MEM_ERR_EN to flag (and suppress) out-of-range accesses.
module dcache_mem_responder
  import dcache_mem_responder_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT,
  parameter int LATENCY   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dcache_mem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);

  type_mem_resp_state_e         state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         wr_q, wr_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [DCACHE_LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                         oob_q, oob_d;

  logic [IDX_W-1:0]             req_idx;
  logic                         req_oob;
  logic                         ram_wr_en;
  logic [IDX_W-1:0]             ram_addr;
  logic [DCACHE_LINE_WIDTH-1:0] ram_wdata;
  logic [DCACHE_LINE_WIDTH-1:0] ram_rdata;
  logic                         unused_addr_bits;

  assign req_idx = bus.dcache2mem_addr_i[DCACHE_OFFSET_BITS +: IDX_W];

`ifdef DCACHE_MEM_ERR_EN
  assign req_oob = |bus.dcache2mem_addr_i[DCACHE_ADDR_WIDTH-1:DCACHE_OFFSET_BITS+IDX_W];
  assign unused_addr_bits = ^bus.dcache2mem_addr_i[DCACHE_OFFSET_BITS-1:0];
`else
  assign req_oob = 1'b0;
  assign unused_addr_bits = ^{bus.dcache2mem_addr_i[DCACHE_ADDR_WIDTH-1:DCACHE_OFFSET_BITS+IDX_W],
                              bus.dcache2mem_addr_i[DCACHE_OFFSET_BITS-1:0]};
`endif

  // The array is driven one cycle ahead of ACK so its registered read (or the
  // write) lands on the same edge that enters ACK.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    oob_d     = oob_q;
    ram_wr_en = 1'b0;
    ram_addr  = idx_q;
    ram_wdata = wdata_q;
    case (state_q)
      IDLE: begin
        ram_addr  = req_idx;
        ram_wdata = bus.dcache2mem_data_i;
        if (bus.dcache2mem_req_i) begin
          wr_d    = bus.dcache2mem_wr_i;
          idx_d   = req_idx;
          wdata_d = bus.dcache2mem_data_i;
          oob_d   = req_oob;
          cnt_d   = CNT_W'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d   = ACK;
            ram_wr_en = bus.dcache2mem_wr_i & ~req_oob;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d   = ACK;
          ram_wr_en = wr_q & ~oob_q;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // No commit may slip through on an edge while reset is held.
    ram_wr_en = ram_wr_en & rst_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      oob_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      oob_q   <= oob_d;
    end
  end

  dcache_mem_array #(
    .DEPTH (MEM_DEPTH),
    .WIDTH (DCACHE_LINE_WIDTH)
  ) u_array (
    .clk     (clk),
    .wr_en_i (ram_wr_en),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign bus.mem2dcache_ack_o  = (state_q == ACK);
  assign bus.mem_busy_o        = (state_q != IDLE);
  assign bus.mem2dcache_data_o = (state_q == ACK && !wr_q && !oob_q) ? ram_rdata : '0;
`ifdef DCACHE_MEM_ERR_EN
  assign bus.mem2dcache_err_o  = (state_q == ACK) && oob_q;
`endif

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Directed + randomized bench for dcache_mem_responder against a line-array model.
module tb_dcache_mem_responder;
  import dcache_mem_responder_pkg::*;

  localparam int MEM_DEPTH = 1024;
  localparam int LATENCY   = 4;
`ifdef DCACHE_MEM_ERR_EN
  localparam bit ERR_BUILD = 1'b1;
`else
  localparam bit ERR_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  logic [127:0] model [int];

  dcache_mem_responder_if bus ();

  dcache_mem_responder #(
    .MEM_DEPTH (MEM_DEPTH),
    .LATENCY   (LATENCY)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 32'd16) % 32'(MEM_DEPTH));
  endfunction

  function automatic bit is_oob(input logic [31:0] a);
    return ERR_BUILD && (a >= 32'(MEM_DEPTH * 16));
  endfunction

  function automatic logic [127:0] model_get(input logic [31:0] a);
    if (model.exists(line_of(a))) return model[line_of(a)];
    return '0;
  endfunction

  task automatic wait_ack(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 8 * LATENCY + 16; i++) begin
      @(negedge clk);
      if (bus.mem2dcache_ack_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check_bit({tag, "_ack_low"}, bus.mem2dcache_ack_o, 1'b0);
    check_bit({tag, "_busy_low"}, bus.mem_busy_o, 1'b0);
    check({tag, "_data_zero"}, bus.mem2dcache_data_o, '0);
  endtask

  // One complete transaction: issue, wait for ack, check it, then check the idle cycle after.
  task automatic do_txn(input bit w, input logic [31:0] a, input logic [127:0] d, input string tag);
    int t0;
    bit seen;
    bit oob;
    logic [127:0] exp_d;
    oob   = is_oob(a);
    exp_d = (!w && !oob) ? model_get(a) : '0;
    @(negedge clk);
    bus.dcache2mem_req_i  = 1'b1;
    bus.dcache2mem_wr_i   = w;
    bus.dcache2mem_addr_i = a;
    bus.dcache2mem_data_i = d;
    t0 = cyc;
    wait_ack(seen);
    check_bit({tag, "_ack_seen"}, seen, 1'b1);
    check({tag, "_latency"}, 128'(cyc - t0), 128'(LATENCY));
    check({tag, "_data"}, bus.mem2dcache_data_o, exp_d);
    check_bit({tag, "_busy_in_ack"}, bus.mem_busy_o, 1'b1);
`ifdef DCACHE_MEM_ERR_EN
    check_bit({tag, "_err"}, bus.mem2dcache_err_o, oob);
`endif
    $display("txn %s wr=%0d addr=%h data_o=%h t=%0d", tag, w, a, bus.mem2dcache_data_o, cyc - t0);
    bus.dcache2mem_req_i = 1'b0;
    if (w && !oob) model[line_of(a)] = d;
    @(negedge clk);
    check_idle({tag, "_after"});
  endtask

  initial begin
    logic [31:0]  pool [8];
    logic [127:0] d;
    logic [31:0]  a;
    int           t0;
    bit           seen;

    rst_n = 1'b0;
    bus.dcache2mem_req_i  = 1'b0;
    bus.dcache2mem_wr_i   = 1'b0;
    bus.dcache2mem_addr_i = '0;
    bus.dcache2mem_data_i = '0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    // Directed: write then read, offset ignore, wrap.
    do_txn(1'b1, 32'h0000_0100, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, "wr_100");
    do_txn(1'b0, 32'h0000_0100, '0, "rd_100");
    do_txn(1'b1, 32'h0000_0200, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, "wr_200");
    do_txn(1'b0, 32'h0000_020C, '0, "rd_20c");
    if (!ERR_BUILD) begin
      do_txn(1'b1, 32'h0000_4010, 128'hA5A5_5A5A_F00D_CAFE_1234_5678_9ABC_DEF0, "wr_4010");
      do_txn(1'b0, 32'h0000_0010, '0, "rd_0010_wrap");
    end

    // Randomized ops over a small line pool, with offset and aliasing noise.
    for (int i = 0; i < 8; i++) begin
      pool[i] = 32'($urandom_range(0, MEM_DEPTH - 1)) * 32'd16;
      do_txn(1'b1, pool[i], {$urandom, $urandom, $urandom, $urandom}, "rnd_init");
    end
    for (int i = 0; i < 24; i++) begin
      a = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 15));
      if (!ERR_BUILD) a = a | (32'($urandom_range(0, 7)) << 14);
      d = {$urandom, $urandom, $urandom, $urandom};
      do_txn(1'($urandom_range(0, 1)), a, d, "rnd");
    end

    // Back-to-back: req held across ack, switching to a read of the same line.
    d = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    @(negedge clk);
    bus.dcache2mem_req_i  = 1'b1;
    bus.dcache2mem_wr_i   = 1'b1;
    bus.dcache2mem_addr_i = 32'h0000_0300;
    bus.dcache2mem_data_i = d;
    t0 = cyc;
    wait_ack(seen);
    check_bit("b2b_first_ack", seen, 1'b1);
    check("b2b_first_latency", 128'(cyc - t0), 128'(LATENCY));
    $display("txn b2b_wr addr=00000300 t=%0d", cyc - t0);
    model[line_of(32'h0000_0300)] = d;
    bus.dcache2mem_wr_i = 1'b0;
    @(negedge clk);
    check_bit("b2b_no_double_ack", bus.mem2dcache_ack_o, 1'b0);
    wait_ack(seen);
    check_bit("b2b_second_ack", seen, 1'b1);
    check("b2b_second_latency", 128'(cyc - t0), 128'(2 * LATENCY + 1));
    check("b2b_read_data", bus.mem2dcache_data_o, model_get(32'h0000_0300));
    $display("txn b2b_rd addr=00000300 data_o=%h t=%0d", bus.mem2dcache_data_o, cyc - t0);
    bus.dcache2mem_req_i = 1'b0;
    @(negedge clk);
    check_idle("b2b_after");

    // req dropped mid-WAIT: transaction still completes.
    @(negedge clk);
    bus.dcache2mem_req_i  = 1'b1;
    bus.dcache2mem_wr_i   = 1'b0;
    bus.dcache2mem_addr_i = 32'h0000_0300;
    t0 = cyc;
    @(negedge clk);
    bus.dcache2mem_req_i = 1'b0;
    wait_ack(seen);
    check_bit("drop_ack", seen, 1'b1);
    check("drop_latency", 128'(cyc - t0), 128'(LATENCY));
    check("drop_data", bus.mem2dcache_data_o, model_get(32'h0000_0300));
    $display("txn drop_rd addr=00000300 data_o=%h", bus.mem2dcache_data_o);
    @(negedge clk);
    check_idle("drop_after");

    // Reset mid-WAIT abandons the write.
    do_txn(1'b1, 32'h0000_0040, 128'hCAFE_0000_0000_0000_0000_0000_0000_0040, "rst_pre_wr");
    @(negedge clk);
    bus.dcache2mem_req_i  = 1'b1;
    bus.dcache2mem_wr_i   = 1'b1;
    bus.dcache2mem_addr_i = 32'h0000_0040;
    bus.dcache2mem_data_i = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
    repeat (2) @(negedge clk);
    check_bit("rst_busy_mid_wait", bus.mem_busy_o, 1'b1);
    rst_n = 1'b0;
    bus.dcache2mem_req_i = 1'b0;
    #1;
    check_idle("rst_async");
    $display("txn rst_mid_wait addr=00000040");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_txn(1'b0, 32'h0000_0040, '0, "rst_post_rd");

`ifdef DCACHE_MEM_ERR_EN
    do_txn(1'b1, 32'h0000_0000, 128'h0BAD_F00D_0000_0000_0000_0000_0000_0000, "err_base_wr");
    do_txn(1'b0, 32'h0001_0000, '0, "err_rd");
    do_txn(1'b1, 32'h0001_0000, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, "err_wr");
    do_txn(1'b0, 32'h0000_0000, '0, "err_base_rd");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
